irq_sequencer: RTL and testbench
================================

# irq_sequencer

Interrupt/exception entry-and-return sequencer for the multicycle core. Latches edge-triggered interrupt requests, waits for an instruction boundary (end of step 4), then in a single cycle redirects the PC to the interrupt vector, records the return PC and the cause, and flushes the step machines via `interrupts_signal`. Exceptions and interrupts are not nested: a second entry is not taken until the handler returns with `eret`.

## Interface
- `N_SRC`, 4: number of interrupt sources (1..8).
- `VECTOR_ADDR`, 32'h0000_0080: handler entry address driven on `vector_pc`.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `irq_src`  in  N_SRC  raw interrupt lines, already synchronous to `clk`; rising edge requests service.
- `step_done`  in  1  one-cycle pulse: current instruction finished step 4 (instruction boundary).
- `pc_next`  in  32  address of the next instruction to execute; valid while `step_done`=1.
- `exc_req`  in  1  synchronous exception raised by the finishing instruction; sampled only with `step_done`.
- `cause_in`  in  3  exception cause; valid with `exc_req`; never 3'b000.
- `eret`  in  1  finishing instruction is a return-from-handler; sampled only with `step_done`.
- `mask_we`  in  1  write enable for the interrupt mask.
- `mask_wdata`  in  N_SRC  new mask; bit=1 enables that source.
- `interrupts_signal`  out  1  one-cycle entry pulse: flush steps, load `vector_pc`.
- `vector_pc`  out  32  constant `VECTOR_ADDR`.
- `epc`  out  32  saved return address.
- `cause_out`  out  3  3'b000 = interrupt, otherwise copy of `cause_in`.
- `irq_id`  out  3  index of the source being serviced.
- `ret_valid`  out  1  one-cycle pulse: load `epc` into PC.
- `in_service`  out  1  high from entry until return.
- `pending`  out  N_SRC  latched, not-yet-serviced requests.

## Operation
- Reset values: state IDLE, `pending`=0, mask=0, `irq_q`=0, `epc`=0, `cause_out`=0, `irq_id`=0, all pulse outputs 0, `in_service`=0.
- Edge detect: `irq_q` <= `irq_src` every cycle; `pending[i]` sets when `irq_src[i] & ~irq_q[i]`. A set and a clear of the same bit in the same cycle: set wins.
- `eligible` = `pending & mask`; selected source = lowest index set in `eligible`.
- States:
  - IDLE: `|eligible` -> WAIT. `step_done & exc_req` -> ENTER (exception), regardless of `eligible`.
  - WAIT: `step_done & exc_req` -> ENTER (exception has priority; interrupt stays pending). `step_done & ~exc_req` with `|eligible` -> ENTER (interrupt). `~|eligible` (mask write or none left) -> IDLE.
  - ENTER (1 cycle): `interrupts_signal`=1. Exception: `cause_out`<=`cause_in`, `irq_id` unchanged. Interrupt: `cause_out`<=3'b000, `irq_id`<=selected index, clear that `pending` bit. `epc`<=`pc_next` captured at the triggering `step_done`. -> SERVICE.
  - SERVICE: `in_service`=1; new edges still set `pending`; no entry taken; `exc_req` ignored. `step_done & eret` -> RETURN.
  - RETURN (1 cycle): `ret_valid`=1, `in_service`=1. -> IDLE, or -> WAIT if `|eligible`.
- `eret` outside SERVICE is ignored.
- Mask writes take effect the cycle after `mask_we`, in any state.
- Entry data (cause, index, `pc_next`) is registered at the `step_done` edge; ENTER drives only registered values.

## Timing
- Edge on `irq_src` at cycle t -> `pending` set at t+1 -> WAIT at t+2 if masked in.
- `step_done` at cycle t in WAIT/IDLE-with-exception -> `interrupts_signal`=1 during t+1; `epc`, `cause_out`, `irq_id` valid from t+1 and held until next entry.
- `step_done & eret` at t in SERVICE -> `ret_valid`=1 during t+1; `in_service` low from t+2.
- Minimum entry-to-entry spacing: ENTER, ≥1 SERVICE cycle, RETURN, then the next boundary.
- Reset asserted mid-operation: immediate return to reset values; pulses drop asynchronously.

## Test plan
- Mask=4'b0010, rising edge on `irq_src[1]`, `step_done` with `pc_next`=0x0000_0040 -> `interrupts_signal` one cycle, `epc`=0x40, `cause_out`=000, `irq_id`=1, `pending[1]` cleared.
- Edges on sources 3 and 1 same cycle, mask=4'b1111 -> first entry `irq_id`=1; after `eret`: `ret_valid`=1, then second entry `irq_id`=3.
- In WAIT with source 0 pending, `step_done` with `exc_req`=1, `cause_in`=3'b101, `pc_next`=0x100 -> `cause_out`=101, `epc`=0x100, `pending[0]` still 1.
- Source 2 pending with mask=0 -> no entry over 20 `step_done` pulses; write mask=4'b0100 -> entry at next `step_done`, `irq_id`=2.
- During SERVICE, edge on source 0 and `exc_req` pulse -> no `interrupts_signal`; `pending[0]`=1; after `eret`, entry with `irq_id`=0.
- `reset` low during SERVICE -> `in_service`=0, `pending`=0, `epc`=0 immediately; `interrupts_signal` stays 0 after release.

Source files
------------

// File: rtl/irq_sequencer.sv
// Interrupt/exception entry-and-return sequencer for the multicycle core.
// Latches interrupt edges, enters the handler at an instruction boundary and returns on eret.
module irq_sequencer #(
    parameter int          N_SRC       = 4,
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0080
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             step_done,
    input  logic [31:0]      pc_next,
    input  logic             exc_req,
    input  logic [2:0]       cause_in,
    input  logic             eret,
    input  logic             mask_we,
    input  logic [N_SRC-1:0] mask_wdata,
    output logic             interrupts_signal,
    output logic [31:0]      vector_pc,
    output logic [31:0]      epc,
    output logic [2:0]       cause_out,
    output logic [2:0]       irq_id,
    output logic             ret_valid,
    output logic             in_service,
    output logic [N_SRC-1:0] pending
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ENTER,
        S_SERVICE,
        S_RETURN
    } state_t;

    state_t           state, state_nxt;
    logic [N_SRC-1:0] irq_q;
    logic [N_SRC-1:0] mask;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] clr_vec;
    logic [2:0]       sel_id;
    logic             take_exc;
    logic             take_irq;
    logic             ent_irq;

    assign vector_pc = VECTOR_ADDR;
    assign eligible  = pending & mask;

    // Lowest-index eligible source wins; scanning downward lets the lowest overwrite.
    always_comb begin
        sel_id = 3'd0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (eligible[i]) sel_id = 3'(i);
        end
    end

    // Serviced bit is dropped during ENTER; a new edge in the same cycle re-sets it.
    always_comb begin
        clr_vec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            clr_vec[i] = (state == S_ENTER) && ent_irq && (irq_id == 3'(i));
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt         = state;
        take_exc          = 1'b0;
        take_irq          = 1'b0;
        interrupts_signal = 1'b0;
        ret_valid         = 1'b0;
        in_service        = 1'b0;
        case (state)
            S_IDLE: begin
                if (step_done && exc_req) begin
                    take_exc  = 1'b1;
                    state_nxt = S_ENTER;
                end else if (|eligible) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (step_done && exc_req) begin
                    take_exc  = 1'b1;
                    state_nxt = S_ENTER;
                end else if (~|eligible) begin
                    state_nxt = S_IDLE;
                end else if (step_done) begin
                    take_irq  = 1'b1;
                    state_nxt = S_ENTER;
                end
            end
            S_ENTER: begin
                interrupts_signal = 1'b1;
                state_nxt         = S_SERVICE;
            end
            S_SERVICE: begin
                in_service = 1'b1;
                if (step_done && eret) state_nxt = S_RETURN;
            end
            S_RETURN: begin
                ret_valid  = 1'b1;
                in_service = 1'b1;
                state_nxt  = (|eligible) ? S_WAIT : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
        end else begin
            state   <= state_nxt;
            irq_q   <= irq_src;
            pending <= (pending & ~clr_vec) | (irq_src & ~irq_q);
            if (mask_we) mask <= mask_wdata;
        end
    end

    // Entry record is captured at the boundary edge so it is valid throughout ENTER.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            epc       <= '0;
            cause_out <= '0;
            irq_id    <= '0;
            ent_irq   <= 1'b0;
        end else if (take_exc) begin
            epc       <= pc_next;
            cause_out <= cause_in;
            ent_irq   <= 1'b0;
        end else if (take_irq) begin
            epc       <= pc_next;
            cause_out <= 3'b000;
            irq_id    <= sel_id;
            ent_irq   <= 1'b1;
        end
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// Self-checking bench for irq_sequencer: directed scenarios plus random traffic,
// all compared each cycle against a flag-based behavioural model.
module tb_irq_sequencer;

    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  irq_src;
    logic          step_done;
    logic [31:0]   pc_next;
    logic          exc_req;
    logic [2:0]    cause_in;
    logic          eret;
    logic          mask_we;
    logic [N-1:0]  mask_wdata;
    logic          interrupts_signal;
    logic [31:0]   vector_pc;
    logic [31:0]   epc;
    logic [2:0]    cause_out;
    logic [2:0]    irq_id;
    logic          ret_valid;
    logic          in_service;
    logic [N-1:0]  pending;

    int n_vec = 0;
    int n_err = 0;

    // Model: pending/mask as bit sets, handler progress as flags.
    logic [N-1:0] m_pend, m_mask, m_irq_q;
    logic [31:0]  m_epc;
    logic [2:0]   m_cause, m_id;
    bit           m_armed, m_enter, m_enter_irq, m_handler, m_ret;

    irq_sequencer #(.N_SRC(N), .VECTOR_ADDR(32'h0000_0080)) dut (
        .clk(clk), .reset(reset), .irq_src(irq_src), .step_done(step_done),
        .pc_next(pc_next), .exc_req(exc_req), .cause_in(cause_in), .eret(eret),
        .mask_we(mask_we), .mask_wdata(mask_wdata),
        .interrupts_signal(interrupts_signal), .vector_pc(vector_pc), .epc(epc),
        .cause_out(cause_out), .irq_id(irq_id), .ret_valid(ret_valid),
        .in_service(in_service), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] lowest(input logic [N-1:0] v);
        logic [2:0] r = 3'd0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = 3'(i);
        return r;
    endfunction

    task automatic model_reset();
        m_pend = '0; m_mask = '0; m_irq_q = '0; m_epc = '0; m_cause = '0; m_id = '0;
        m_armed = 0; m_enter = 0; m_enter_irq = 0; m_handler = 0; m_ret = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] elig, clr;
        bit idle_like, t_exc, t_irq, n_armed, n_handler, n_ret;
        elig      = m_pend & m_mask;
        idle_like = !(m_enter || m_handler || m_ret);
        t_exc     = idle_like && step_done && exc_req;
        t_irq     = idle_like && m_armed && step_done && !exc_req && (elig != 0);
        clr       = (m_enter && m_enter_irq) ? (N'(1) << m_id) : '0;
        n_armed   = ((idle_like && !t_exc && !t_irq) || m_ret) && (elig != 0);
        n_handler = m_enter || (m_handler && !(step_done && eret));
        n_ret     = m_handler && step_done && eret;
        m_pend    = (m_pend & ~clr) | (irq_src & ~m_irq_q);
        m_irq_q   = irq_src;
        if (mask_we) m_mask = mask_wdata;
        if (t_exc) begin
            m_epc = pc_next; m_cause = cause_in; m_enter_irq = 0;
        end
        if (t_irq) begin
            m_epc = pc_next; m_cause = 3'b000; m_id = lowest(elig); m_enter_irq = 1;
        end
        m_enter   = t_exc || t_irq;
        m_armed   = n_armed;
        m_handler = n_handler;
        m_ret     = n_ret;
    endtask

    task automatic check_all();
        check("interrupts_signal", interrupts_signal, m_enter);
        check("ret_valid", ret_valid, m_ret);
        check("in_service", in_service, m_handler || m_ret);
        check("pending", pending, m_pend);
        check("epc", epc, m_epc);
        check("cause_out", cause_out, m_cause);
        check("irq_id", irq_id, m_id);
        check("vector_pc", vector_pc, 32'h0000_0080);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_step();
        else model_reset();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_step(input logic [31:0] pc, input bit exc, input logic [2:0] cause, input bit er);
        step_done = 1'b1; pc_next = pc; exc_req = exc; cause_in = cause; eret = er;
        tick();
        step_done = 1'b0; exc_req = 1'b0; eret = 1'b0;
    endtask

    task automatic write_mask(input logic [N-1:0] m);
        mask_we = 1'b1; mask_wdata = m;
        tick();
        mask_we = 1'b0;
    endtask

    initial begin
        int seen;
        reset = 1'b0; irq_src = '0; step_done = 0; pc_next = '0; exc_req = 0;
        cause_in = 3'd1; eret = 0; mask_we = 0; mask_wdata = '0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        run(2);

        // Single masked-in source enters at the next boundary.
        write_mask(4'b0010);
        irq_src = 4'b0010; tick();
        run(1);
        pulse_step(32'h40, 0, 3'd1, 0);
        check("tp1_int", interrupts_signal, 1);
        check("tp1_epc", epc, 32'h40);
        check("tp1_cause", cause_out, 0);
        check("tp1_id", irq_id, 1);
        run(1);
        check("tp1_pend_clr", pending[1], 0);
        pulse_step(32'h44, 0, 3'd1, 1);
        run(1);

        // Simultaneous edges: lowest index first, the other after eret.
        irq_src = '0; run(1);
        write_mask(4'b1111);
        irq_src = 4'b1010; tick();
        run(1);
        pulse_step(32'h200, 0, 3'd1, 0);
        check("tp2_id_first", irq_id, 1);
        run(1);
        pulse_step(32'h204, 0, 3'd1, 1);
        check("tp2_ret", ret_valid, 1);
        run(1);
        pulse_step(32'h208, 0, 3'd1, 0);
        check("tp2_id_second", irq_id, 3);
        run(1);
        pulse_step(32'h20c, 0, 3'd1, 1);
        run(1);

        // Exception in WAIT beats the pending interrupt.
        irq_src = '0; run(1);
        irq_src = 4'b0001; tick();
        run(1);
        pulse_step(32'h100, 1, 3'b101, 0);
        check("tp3_cause", cause_out, 3'b101);
        check("tp3_epc", epc, 32'h100);
        check("tp3_pend0", pending[0], 1);
        run(1);
        pulse_step(32'h104, 0, 3'd1, 1);
        run(1);
        pulse_step(32'h108, 0, 3'd1, 0);
        check("tp3_id_later", irq_id, 0);
        run(1);
        pulse_step(32'h10c, 0, 3'd1, 1);
        run(1);

        // Masked-off source never enters until unmasked.
        irq_src = '0; write_mask(4'b0000);
        irq_src = 4'b0100; tick();
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            pulse_step(32'h300 + 32'(i), 0, 3'd1, 0);
            seen += int'(interrupts_signal);
            tick();
            seen += int'(interrupts_signal);
        end
        check("tp4_no_entry", seen, 0);
        write_mask(4'b0100);
        run(1);
        pulse_step(32'h400, 0, 3'd1, 0);
        check("tp4_id", irq_id, 2);
        run(1);
        pulse_step(32'h404, 0, 3'd1, 1);
        run(1);

        // Edge and exception during SERVICE are deferred.
        irq_src = '0; write_mask(4'b1111);
        pulse_step(32'h500, 1, 3'd3, 0);
        run(1);
        irq_src = 4'b0001;
        pulse_step(32'h504, 1, 3'd6, 0);
        check("tp5_no_int", interrupts_signal, 0);
        run(1);
        check("tp5_pend0", pending[0], 1);
        check("tp5_cause_held", cause_out, 3'd3);
        pulse_step(32'h508, 0, 3'd1, 1);
        run(1);
        pulse_step(32'h50c, 0, 3'd1, 0);
        check("tp5_id", irq_id, 0);
        run(1);
        pulse_step(32'h510, 0, 3'd1, 1);
        run(1);

        // Asynchronous reset in SERVICE.
        irq_src = '0;
        pulse_step(32'h600, 1, 3'd2, 0);
        run(1);
        irq_src = 4'b0010; tick();
        reset = 1'b0;
        #1;
        check("rst_in_service", in_service, 0);
        check("rst_pending", pending, 0);
        check("rst_epc", epc, 0);
        check("rst_int", interrupts_signal, 0);
        model_reset();
        run(2);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse_step(32'h700, 0, 3'd1, 0);
            check("rst_after_int", interrupts_signal, 0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) irq_src = irq_src ^ N'(1 << $urandom_range(0, N - 1));
            step_done  = ($urandom_range(0, 2) == 0);
            exc_req    = step_done && ($urandom_range(0, 7) == 0);
            cause_in   = 3'($urandom_range(1, 7));
            eret       = step_done && ($urandom_range(0, 1) == 0);
            pc_next    = $urandom;
            mask_we    = ($urandom_range(0, 19) == 0);
            mask_wdata = N'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
